// File: rtl/pong_pkg.sv
// Shared Pong display-path definitions: screen size, default paddle size,
// colour constants, coordinate typedefs and the blitter state encoding.
package pong_pkg;

  localparam int SCREEN_W     = 160;
  localparam int SCREEN_H     = 120;
  localparam int PADDLE_W_DEF = 4;
  localparam int PADDLE_H_DEF = 16;

  localparam logic [2:0] COL_BLACK = 3'b000;
  localparam logic [2:0] COL_WHITE = 3'b111;

  typedef logic [7:0] xcoord_t;
  typedef logic [6:0] ycoord_t;

  // Raster counter widths cover the largest supported paddle (16 x 64).
  typedef logic [3:0] col_t;
  typedef logic [5:0] row_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DRAW = 2'd1,
    ST_DONE = 2'd2
  } plot_state_e;

  // Debug view of the plotter: FSM state plus "current pixel lies off screen".
  typedef struct packed {
    plot_state_e state;
    logic        offscreen;
  } plot_dbg_t;

endpackage

// File: rtl/raster_counter.sv
// Column/row counter pair for rectangle blitters. Column runs fastest; the
// row advances when the column wraps. 'last' flags the final pixel.
module raster_counter
  import pong_pkg::*;
#(
  parameter int COLS = 4,
  parameter int ROWS = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic advance,
  output col_t col,
  output row_t row,
  output logic last
);

  localparam col_t COL_LAST = col_t'(COLS - 1);
  localparam row_t ROW_LAST = row_t'(ROWS - 1);

  col_t col_q, col_d;
  row_t row_q, row_d;

  // Next-count logic: clear wins, otherwise step in raster order and wrap.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clear) begin
      col_d = '0;
      row_d = '0;
    end else if (advance) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + row_t'(1);
      end else begin
        col_d = col_q + col_t'(1);
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col  = col_q;
  assign row  = row_q;
  assign last = (col_q == COL_LAST) && (row_q == ROW_LAST);

endmodule

// File: rtl/paddle_plotter.sv
// Paddle rasteriser: latches an origin and colour per request and emits one
// pixel per clock over a PADDLE_W x PADDLE_H rectangle to the VGA write port.
// Optional screen-edge clipping is enabled by defining PADDLE_PLOTTER_CLIP_EN.
//
// Handshake: ready is high only in IDLE; a request is accepted on the clock
// edge where go=1 and ready=1. go at any other time is ignored, not queued.
module paddle_plotter
  import pong_pkg::*;
#(
  parameter int PADDLE_W = PADDLE_W_DEF,
  parameter int PADDLE_H = PADDLE_H_DEF,
  parameter int SCREEN_W = pong_pkg::SCREEN_W,
  parameter int SCREEN_H = pong_pkg::SCREEN_H
) (
  input  logic      CLOCK_50,
  input  logic      resetn,
  input  logic      go,
  input  logic [7:0] x_in,
  input  logic [6:0] y_in,
  input  logic [2:0] colour_in,
  output logic      ready,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic      plot,
  output logic      done,
  output plot_dbg_t dbg
);

  plot_state_e state_q, state_d;
  xcoord_t     ox_q, ox_d;
  ycoord_t     oy_q, oy_d;
  logic [2:0]  colour_q, colour_d;

  col_t col;
  row_t row;
  logic last;
  logic cnt_clear;
  logic cnt_advance;

  logic [8:0] x_sum;
  logic [7:0] y_sum;
  logic       offscreen;

  raster_counter #(
    .COLS(PADDLE_W),
    .ROWS(PADDLE_H)
  ) u_raster (
    .clk    (CLOCK_50),
    .rst_n  (resetn),
    .clear  (cnt_clear),
    .advance(cnt_advance),
    .col    (col),
    .row    (row),
    .last   (last)
  );

  // Next-state logic: accept in IDLE, sweep the rectangle in DRAW, pulse DONE.
  always_comb begin
    state_d     = state_q;
    ox_d        = ox_q;
    oy_d        = oy_q;
    colour_d    = colour_q;
    cnt_clear   = 1'b0;
    cnt_advance = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (go) begin
          ox_d      = x_in;
          oy_d      = y_in;
          colour_d  = colour_in;
          cnt_clear = 1'b1;
          state_d   = ST_DRAW;
        end
      end
      ST_DRAW: begin
        cnt_advance = 1'b1;
        if (last) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and request registers; reset aborts any draw in progress.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      ox_q     <= '0;
      oy_q     <= '0;
      colour_q <= '0;
    end else begin
      state_q  <= state_d;
      ox_q     <= ox_d;
      oy_q     <= oy_d;
      colour_q <= colour_d;
    end
  end

  // Sums keep one extra bit so the off-screen test sees the true coordinate;
  // the pixel outputs show the truncated (wrapped) value.
  assign x_sum     = {1'b0, ox_q} + {5'b0, col};
  assign y_sum     = {1'b0, oy_q} + {2'b0, row};
  assign offscreen = (x_sum >= 9'(SCREEN_W)) || (y_sum >= 8'(SCREEN_H));

  // Outputs decode registers only, so nothing combinational leaks from go/x_in.
  assign ready  = (state_q == ST_IDLE);
  assign done   = (state_q == ST_DONE);
  assign x      = x_sum[7:0];
  assign y      = y_sum[6:0];
  assign colour = colour_q;
`ifdef PADDLE_PLOTTER_CLIP_EN
  assign plot   = (state_q == ST_DRAW) && !offscreen;
`else
  assign plot   = (state_q == ST_DRAW);
`endif

  assign dbg.state     = state_q;
  assign dbg.offscreen = offscreen;

endmodule

// File: tb/tb_paddle_plotter.sv
// Bench for paddle_plotter: randomised and directed requests checked against a
// rectangle model built from plain arithmetic. Honours PADDLE_PLOTTER_CLIP_EN.
module tb_paddle_plotter;
  import pong_pkg::*;

  localparam int PW = 4;
  localparam int PH = 16;

  logic       clk = 1'b0;
  logic       resetn;
  logic       go;
  logic [7:0] x_in;
  logic [6:0] y_in;
  logic [2:0] colour_in;
  logic       ready;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       done;
  plot_dbg_t  dbg;

  int n_cmp = 0;
  int n_err = 0;

  // pixel record: {plot, colour[2:0], x[7:0], y[6:0]}
  logic [18:0] exp_q[$];
  logic [18:0] obs_q[$];

  paddle_plotter dut (
    .CLOCK_50 (clk),
    .resetn   (resetn),
    .go       (go),
    .x_in     (x_in),
    .y_in     (y_in),
    .colour_in(colour_in),
    .ready    (ready),
    .x        (x),
    .y        (y),
    .colour   (colour),
    .plot     (plot),
    .done     (done),
    .dbg      (dbg)
  );

  // ---------------- clock ----------------
  always #10 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic void build_exp(input int ox, input int oy, input logic [2:0] c);
    exp_q.delete();
    for (int r = 0; r < PH; r++) begin
      for (int cc = 0; cc < PW; cc++) begin
        int px;
        int py;
        logic vis;
        px = ox + cc;
        py = oy + r;
`ifdef PADDLE_PLOTTER_CLIP_EN
        vis = (px < 160) && (py < 120);
`else
        vis = 1'b1;
`endif
        exp_q.push_back({vis, c, 8'(px % 256), 7'(py % 128)});
      end
    end
  endfunction

  // ---------------- drivers ----------------
  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Issues one request and records every busy non-done cycle into obs_q.
  // At busy cycle 'poke' go is pulsed with a different origin and colour.
  task automatic run_draw(input logic [7:0] ox, input logic [6:0] oy, input logic [2:0] c,
                          input int poke, output bit first_busy, output bit timeout,
                          output int dones, output bit ready_after, output int extra_plots);
    bit ok;
    obs_q.delete();
    first_busy = 1'b0; timeout = 1'b1; dones = 0; ready_after = 1'b0; extra_plots = 0;
    wait_idle(ok);
    if (!ok) return;
    go = 1'b1; x_in = ox; y_in = oy; colour_in = c;
    @(negedge clk);
    go = 1'b0;
    first_busy = (ready === 1'b0);
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (ready === 1'b0 && done === 1'b0) obs_q.push_back({plot, colour, x, y});
      if (done === 1'b1) begin
        timeout = 1'b0;
        break;
      end
      if (cyc == poke) begin
        go = 1'b1; x_in = 8'd50; y_in = 7'd50; colour_in = ~c;
      end else if (cyc == poke + 1) begin
        go = 1'b0;
      end
    end
    go = 1'b0;
    if (timeout) return;
    dones = 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 0) ready_after = (ready === 1'b1);
      if (done !== 1'b0) dones++;
      if (plot !== 1'b0) extra_plots++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    resetn = 1'b0; go = 1'b0; x_in = '0; y_in = '0; colour_in = '0;
    #5;
    n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", ready); end
    n_cmp++; if (plot !== 1'b0) begin n_err++; $display("FAIL reset_plot got %b want 0", plot); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
    n_cmp++; if ({x, y, colour} !== 18'd0) begin n_err++; $display("FAIL reset_xyc got %h want 0", {x, y, colour}); end
    n_cmp++; if (dbg.state !== ST_IDLE) begin n_err++; $display("FAIL reset_state got %0d want %0d", dbg.state, ST_IDLE); end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_basic;
    bit fb, to, ra;
    int dn, ep;
    logic [18:0] e;
    build_exp(0, 54, COL_WHITE);
    run_draw(8'd0, 7'd54, COL_WHITE, -1, fb, to, dn, ra, ep);
    n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL basic_timeout got %b want 0", to); end
    n_cmp++; if (fb !== 1'b1) begin n_err++; $display("FAIL basic_first_busy got %b want 1", fb); end
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL basic_len got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL basic_pix[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    if (obs_q.size() >= 64) begin
      e = obs_q[0];
      n_cmp++; if (e[14:0] !== {8'd0, 7'd54}) begin n_err++; $display("FAIL basic_first got %0d,%0d want 0,54", e[14:7], e[6:0]); end
      e = obs_q[4];
      n_cmp++; if (e[14:0] !== {8'd0, 7'd55}) begin n_err++; $display("FAIL basic_fifth got %0d,%0d want 0,55", e[14:7], e[6:0]); end
      e = obs_q[63];
      n_cmp++; if (e[14:0] !== {8'd3, 7'd69}) begin n_err++; $display("FAIL basic_last got %0d,%0d want 3,69", e[14:7], e[6:0]); end
    end
    n_cmp++; if (dn != 1) begin n_err++; $display("FAIL basic_done_count got %0d want 1", dn); end
    n_cmp++; if (ra !== 1'b1) begin n_err++; $display("FAIL basic_ready_after got %b want 1", ra); end
    n_cmp++; if (ep != 0) begin n_err++; $display("FAIL basic_extra_plot got %0d want 0", ep); end
  endtask

  task automatic test_colour_hold;
    bit fb, to, ra;
    int dn, ep;
    build_exp(118, 54, 3'b100);
    run_draw(8'd118, 7'd54, 3'b100, 7, fb, to, dn, ra, ep);
    n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL colour_timeout got %b want 0", to); end
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL colour_len got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL colour_pix[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    n_cmp++; if (dn != 1) begin n_err++; $display("FAIL colour_done_count got %0d want 1", dn); end
  endtask

  task automatic test_ignore_busy;
    bit fb, to, ra;
    int dn, ep;
    build_exp(20, 30, 3'b010);
    run_draw(8'd20, 7'd30, 3'b010, 10, fb, to, dn, ra, ep);
    n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL busy_timeout got %b want 0", to); end
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL busy_len got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL busy_pix[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    n_cmp++; if (dn != 1) begin n_err++; $display("FAIL busy_done_count got %0d want 1", dn); end
    n_cmp++; if (ep != 0) begin n_err++; $display("FAIL busy_extra_plot got %0d want 0", ep); end
  endtask

  task automatic test_reset_mid;
    bit ok;
    int bad_plot, bad_done, bad_ready;
    wait_idle(ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL rstmid_idle got busy want ready"); end
    go = 1'b1; x_in = 8'd10; y_in = 7'd20; colour_in = 3'b011;
    @(negedge clk);
    go = 1'b0;
    repeat (20) @(negedge clk);
    n_cmp++; if (plot !== 1'b1) begin n_err++; $display("FAIL rstmid_plotting got %b want 1", plot); end
    #2 resetn = 1'b0;
    #1;
    n_cmp++; if (plot !== 1'b0) begin n_err++; $display("FAIL rstmid_plot got %b want 0", plot); end
    n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL rstmid_ready got %b want 1", ready); end
    n_cmp++; if ({x, y, done} !== 16'd0) begin n_err++; $display("FAIL rstmid_xyd got %h want 0", {x, y, done}); end
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    bad_plot = 0; bad_done = 0; bad_ready = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (plot !== 1'b0) bad_plot++;
      if (done !== 1'b0) bad_done++;
      if (ready !== 1'b1) bad_ready++;
    end
    n_cmp++; if (bad_plot != 0) begin n_err++; $display("FAIL rstmid_no_plot got %0d want 0", bad_plot); end
    n_cmp++; if (bad_done != 0) begin n_err++; $display("FAIL rstmid_no_done got %0d want 0", bad_done); end
    n_cmp++; if (bad_ready != 0) begin n_err++; $display("FAIL rstmid_stay_idle got %0d want 0", bad_ready); end
  endtask

  // go held high across two requests; trace = {ready, done, plot, x, y}
  // with x/y masked to zero on non-plot cycles.
  task automatic test_back_to_back;
    bit ok;
    logic [17:0] obs_t[$];
    logic [17:0] exp_t[$];
    wait_idle(ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL b2b_idle got busy want ready"); end
    for (int i = 0; i < 136; i++) begin
      int k;
      int p;
      k = i / 66;
      p = i % 66;
      if (k >= 2) exp_t.push_back({3'b100, 15'd0});
      else if (p < 64) exp_t.push_back({3'b001, 8'((k == 0 ? 0 : 118) + p % PW), 7'(p / PW)});
      else if (p == 64) exp_t.push_back({3'b010, 15'd0});
      else exp_t.push_back({3'b100, 15'd0});
    end
    go = 1'b1; x_in = 8'd0; y_in = 7'd0; colour_in = COL_WHITE;
    for (int i = 0; i < 136; i++) begin
      @(negedge clk);
      obs_t.push_back({ready, done, plot, plot ? x : 8'd0, plot ? y : 7'd0});
      if (i == 1) x_in = 8'd118;
      if (i == 66) go = 1'b0;
    end
    go = 1'b0;
    for (int i = 0; i < 136; i++) begin
      n_cmp++; if (obs_t[i] !== exp_t[i]) begin n_err++; $display("FAIL b2b_trace[%0d] got %h want %h", i, obs_t[i], exp_t[i]); end
    end
  endtask

  task automatic test_clip;
    bit fb, to, ra;
    int dn, ep, n_plot, want_plot;
    int ox, oy;
`ifdef PADDLE_PLOTTER_CLIP_EN
    ox = 158; oy = 110; want_plot = 20;
`else
    ox = 254; oy = 120; want_plot = 64;
`endif
    build_exp(ox, oy, 3'b001);
    run_draw(8'(ox), 7'(oy), 3'b001, -1, fb, to, dn, ra, ep);
    n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL clip_timeout got %b want 0", to); end
    n_cmp++; if (obs_q.size() != 64) begin n_err++; $display("FAIL clip_cycles got %0d want 64", obs_q.size()); end
    n_plot = 0;
    for (int i = 0; i < obs_q.size(); i++) if (obs_q[i][18]) n_plot++;
    n_cmp++; if (n_plot != want_plot) begin n_err++; $display("FAIL clip_plot_count got %0d want %0d", n_plot, want_plot); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL clip_pix[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    n_cmp++; if (dn != 1) begin n_err++; $display("FAIL clip_done_count got %0d want 1", dn); end
  endtask

  task automatic test_random;
    bit fb, to, ra;
    int dn, ep;
    logic [7:0] ox;
    logic [6:0] oy;
    logic [2:0] c;
    for (int t = 0; t < 6; t++) begin
      ox = 8'($urandom_range(0, 255));
      oy = 7'($urandom_range(0, 127));
      c  = 3'($urandom_range(0, 7));
      build_exp(int'(ox), int'(oy), c);
      run_draw(ox, oy, c, int'($urandom_range(0, 60)), fb, to, dn, ra, ep);
      n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL rand%0d_timeout got %b want 0", t, to); end
      n_cmp++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL rand%0d_len got %0d want %0d", t, obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rand%0d_pix[%0d] got %h want %h", t, i, obs_q[i], exp_q[i]); end
      end
      n_cmp++; if (dn != 1) begin n_err++; $display("FAIL rand%0d_done_count got %0d want 1", t, dn); end
      n_cmp++; if (ra !== 1'b1) begin n_err++; $display("FAIL rand%0d_ready_after got %b want 1", t, ra); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_colour_hold();
    test_ignore_busy();
    test_reset_mid();
    test_back_to_back();
    test_clip();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
